streaming_sha256_wide: RTL and testbench
========================================

# streaming_sha256_wide

Parametrised streaming SHA-256 hasher with a configurable input word width, ready/valid backpressure and an optional runtime SHA-224 mode. Bytes arrive MSB-first through `update` beats. The block buffers one 64-byte message block, compresses at one round per clock, and on `finalize` appends padding and the 64-bit length. It sits behind bus/DMA adapters in crypto and secure-boot datapaths and generalises the fixed 32-bit streaming hasher.

## Interface
- `IN_BYTES`, 4: bytes per `update` beat; legal values 1, 2, 4, 8.
- `clk` in 1: single clock; everything in the block is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new message; aborts any message in progress.
- `mode_224` in 1: sampled on `start`; selects SHA-224. Present only with the macro.
- `update` in 1: data beat; accepted only when `ready`=1.
- `data_in` in IN_BYTES*8: beat data; byte 0 in bits [MSB:MSB-7].
- `bytes_valid` in $clog2(IN_BYTES+1): number of valid left-justified bytes, 0..IN_BYTES.
- `finalize` in 1: end of message; accepted only when `ready`=1.
- `ready` out 1: block can accept `update`/`finalize`.
- `hash_valid` out 1: one-cycle pulse when the digest is available.
- `hash` out 256: digest, big-endian; held until the next `start`.
- `overflow` out 1: sticky protocol-error flag; cleared by `start`.

## Operation
- FSM states: IDLE, ABSORB, COMPRESS, PAD, DONE.
- IDLE: `ready`=0. `start` loads the IV and clears the length counter and buffer; next state ABSORB.
- ABSORB: `ready`=1.
  - An accepted `update` appends `bytes_valid` bytes and adds 8*`bytes_valid` to the 64-bit bit-length counter.
  - `bytes_valid`=0 is a no-op.
  - `bytes_valid`<IN_BYTES is legal only on the last beat before `finalize`.
  - When the buffer reaches 64 bytes, go to COMPRESS.
- COMPRESS: 64 round cycles plus 1 feed-forward cycle in which the working variables are added to H. Returns to ABSORB, or to PAD/DONE when finalizing.
- PAD, entered on `finalize`:
  - Write 0x80 after the last byte, zero-fill, and put the bit length in bytes 56..63.
  - If fewer than 9 bytes remain after the data, pad the current block without the length, compress it, then build a zero-plus-length block and compress that.
- DONE: register H into `hash`, pulse `hash_valid`, go to IDLE.
- `update` or `finalize` while `ready`=0 (outside IDLE after `start`): the beat is dropped and `overflow` is set.
- `start` has priority over `update`/`finalize` in the same cycle; the beat is dropped and `overflow` is not set.
- `start` in any state: abort immediately and restart from IV. `hash` keeps its old value until the next DONE.
- Length counter wraps modulo 2^64; no error is raised.

## Timing
- Reset values: `ready`=0, `hash_valid`=0, `hash`=0, `overflow`=0, state IDLE.
- `start` at cycle S gives `ready`=1 at S+1.
- Block completed by the beat accepted at N: `ready`=0 for N+1..N+65, and `ready`=1 again at N+66.
- `finalize` at F, single pad block:
  - F+1: pad cycle.
  - F+2..F+65: rounds.
  - F+66: feed-forward.
  - F+67: `hash_valid`=1.
- `finalize` at F, two pad blocks: `hash_valid` at F+133.
- `rst` asserted mid-compression: immediate return to reset values. No partial digest is ever flagged valid.

## Configuration
- `STREAMING_SHA256_SHA224_EN` defined:
  - `mode_224` port exists.
  - With `mode_224`=1 at `start`, the SHA-224 IV is loaded.
  - `hash[255:32]` carries the 224-bit digest and `hash[31:0]` is 0.
- Undefined: no `mode_224` port; SHA-256 only.

## Structure
- Package `sha256_pkg`:
  - K[0:63] constant array.
  - SHA-256 and SHA-224 IV constants.
  - FSM state enum.
  - Ch, Maj, Σ0, Σ1, σ0 and σ1 functions.
- Sub-module `sha256_compress`:
  - Holds the 16-word rolling message schedule and working variables a..h.
  - Handshake: `go` with a 512-bit block and H in; `done` with new H out.
- The top level keeps the FSM, byte packing, padding and the length counter.

## Test plan
- IN_BYTES=4: `start`, one `update` of "a" (`bytes_valid`=1), `finalize` → `hash`=ca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb, with `hash_valid` exactly at F+67.
- `start` then immediate `finalize` (empty message) → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- IN_BYTES=8: 8 beats of "AAAAAAAA", `finalize` → d53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6. Check `ready` low for exactly 65 cycles after the 8th beat.
- IN_BYTES=4: 63×'A' (last beat `bytes_valid`=3) → 1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f, with `hash_valid` at F+133.
- Drive `update` while `ready`=0 → `overflow`=1, digest still correct for the accepted bytes. Then `start` mid-message and hash "a" → correct digest, `overflow`=0.
- Macro defined, `mode_224`=1, message "abc" → `hash[255:32]`=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 and `hash[31:0]`=0. Separately, assert `rst` during COMPRESS → all outputs return to reset values.

Source files
------------

// File: rtl/sha256_pkg.sv
// -----------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions for streaming_sha256_wide and sha256_compress:
//   K       : the 64 round constants
//   IV_256  : SHA-256 initial hash value
//   IV_224  : SHA-224 initial hash value
//   state_t : top-level FSM states
//   ch, maj, bsig0, bsig1, ssig0, ssig1 : the SHA-2 logical functions
//             (bsig = upper-case sigma, ssig = lower-case sigma)
// -----------------------------------------------------------------------------
package sha256_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_COMPRESS,
    ST_PAD,
    ST_DONE
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// -----------------------------------------------------------------------------
// sha256_compress
// One SHA-256 block compression, one round per clock.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   go       : load block + h_in; rounds start on the following cycle
//   abort    : cancel any compression in progress (wins over go)
//   block    : 512-bit message block, big-endian words
//   h_in     : chaining value the block is compressed into
//   done     : high for the single feed-forward cycle after round 63
//   h_out    : h_in + working variables; valid while done is high
// Latency: go sampled at edge L, rounds on edges L+1..L+64, done in the
// cycle after edge L+64.
// -----------------------------------------------------------------------------
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic         abort,
  input  logic [511:0] block,
  input  logic [255:0] h_in,
  output logic         done,
  output logic [255:0] h_out
);

  logic         busy;
  logic [6:0]   rnd;
  logic [31:0]  w [16];  // rolling schedule window, w[0] = W[t]
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] h_base;
  logic [31:0]  t1, t2, w_new;
  logic         last;

  assign last = (rnd == 7'd64);
  assign done = busy && last;

  always_comb begin
    t1    = h + bsig1(e) + ch(e, f, g) + K[rnd[5:0]] + w[0];
    t2    = bsig0(a) + maj(a, b, c);
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  assign h_out = {h_base[255:224] + a, h_base[223:192] + b,
                  h_base[191:160] + c, h_base[159:128] + d,
                  h_base[127:96]  + e, h_base[95:64]   + f,
                  h_base[63:32]   + g, h_base[31:0]    + h};

  // NOTE: sequential state is always written with <=, so every register
  // samples the pre-edge value of its neighbours (the shift chains rely on it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      rnd  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      rnd  <= '0;
    end else if (go) begin
      busy <= 1'b1;
      rnd  <= '0;
    end else if (busy) begin
      if (last) busy <= 1'b0;
      else      rnd  <= rnd + 7'd1;
    end
  end

  // NOTE: the schedule window and working variables carry no reset; they are
  // always loaded by go before being read, and busy gates every use of them.
  always_ff @(posedge clk) begin
    if (go && !abort) begin
      for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
      {a, b, c, d, e, f, g, h} <= h_in;
      h_base <= h_in;
    end else if (busy && !last) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
      h <= g;
      g <= f;
      f <= e;
      e <= d + t1;
      d <= c;
      c <= b;
      b <= a;
      a <= t1 + t2;
    end
  end

endmodule

// File: rtl/streaming_sha256_wide.sv
// -----------------------------------------------------------------------------
// streaming_sha256_wide
// Streaming SHA-256 hasher with IN_BYTES-wide update beats. Bytes are packed
// MSB-first into a 64-byte block buffer, each full block is compressed at one
// round per clock, and finalize appends padding plus the 64-bit bit length.
// Optional build macro: STREAMING_SHA256_SHA224_EN adds mode_224 (SHA-224).
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : begin a new message, aborting any message in progress
//   mode_224    : (macro only) sampled on start, selects the SHA-224 IV
//   update      : data beat, accepted when ready
//   data_in     : beat data, byte 0 in the top byte lane
//   bytes_valid : number of valid left-justified bytes in data_in
//   finalize    : end of message, accepted when ready
//   ready       : high in the absorb state only
//   hash_valid  : one-cycle digest strobe
//   hash        : big-endian digest (SHA-224: low 32 bits are zero)
//   overflow    : sticky, set by update/finalize while busy; cleared by start
// -----------------------------------------------------------------------------
module streaming_sha256_wide
  import sha256_pkg::*;
#(
  parameter  int IN_BYTES = 4,
  localparam int BVW      = $clog2(IN_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef STREAMING_SHA256_SHA224_EN
  input  logic                  mode_224,
`endif
  input  logic                  update,
  input  logic [IN_BYTES*8-1:0] data_in,
  input  logic [BVW-1:0]        bytes_valid,
  input  logic                  finalize,
  output logic                  ready,
  output logic                  hash_valid,
  output logic [255:0]          hash,
  output logic                  overflow
);

  state_t              st;
  logic [511:0]        blk;        // bytes not yet written are always zero
  logic [6:0]          cnt;        // bytes currently held in blk
  logic [63:0]         bit_len;
  logic [255:0]        h_st;
  logic                finalizing; // next compress completion ends the message
  logic                need_len;   // length did not fit, a second pad block follows
  logic                len_only;   // current pad block is zeros plus length
  logic                is_224;
  logic                mode_sel;

  logic [6:0]          bv_eff;
  logic [IN_BYTES*8-1:0] beat_mask;
  logic [511:0]        beat_wide, blk_merge, pad_blk, cmp_block;
  logic [6:0]          cnt_merge;
  logic                acc_update, acc_final, blk_full, ovf_evt, cmp_go, cmp_done;
  logic [255:0]        h_new;

`ifdef STREAMING_SHA256_SHA224_EN
  assign mode_sel = mode_224;
`else
  assign mode_sel = 1'b0;
`endif

  assign ready = (st == ST_ABSORB);

  // finalize wins over an update in the same cycle; start wins over both and
  // never counts as an overflow.
  assign acc_final  = finalize && (st == ST_ABSORB) && !start;
  assign acc_update = update && !finalize && (st == ST_ABSORB) && !start;
  assign ovf_evt    = (update || finalize) && !start &&
                      (st != ST_IDLE) && (st != ST_ABSORB);

  // NOTE: every always_comb output gets a value on every path (defaults
  // first, or assigned in all branches) so no latch is inferred.
  always_comb begin
    bv_eff = 7'(bytes_valid);
    if (bv_eff > 7'(IN_BYTES)) bv_eff = 7'(IN_BYTES);
    beat_mask = ~({(IN_BYTES*8){1'b1}} >> {bv_eff, 3'b000});
    beat_wide = {data_in & beat_mask, {(512-IN_BYTES*8){1'b0}}};
    blk_merge = blk | (beat_wide >> {cnt, 3'b000});
    cnt_merge = cnt + bv_eff;
    if (len_only) begin
      pad_blk = {448'd0, bit_len};
    end else begin
      pad_blk = blk | ({8'h80, 504'd0} >> {cnt, 3'b000});
      // With at most 55 data bytes the length fits in bytes 56..63 (still zero).
      if (cnt <= 7'd55) pad_blk[63:0] = bit_len;
    end
  end

  // A full block is handed to the compressor on the same edge that accepts
  // its last beat, so rounds begin in the very next cycle.
  assign blk_full  = acc_update && (cnt_merge == 7'd64);
  assign cmp_go    = blk_full || ((st == ST_PAD) && !start);
  assign cmp_block = (st == ST_PAD) ? pad_blk : blk_merge;

  sha256_compress u_compress (
    .clk   (clk),
    .rst   (rst),
    .go    (cmp_go),
    .abort (start),
    .block (cmp_block),
    .h_in  (h_st),
    .done  (cmp_done),
    .h_out (h_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      blk        <= '0;
      cnt        <= '0;
      bit_len    <= '0;
      h_st       <= '0;
      finalizing <= 1'b0;
      need_len   <= 1'b0;
      len_only   <= 1'b0;
      is_224     <= 1'b0;
      hash       <= '0;
      hash_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      hash_valid <= 1'b0;
      if (start) begin
        st         <= ST_ABSORB;
        blk        <= '0;
        cnt        <= '0;
        bit_len    <= '0;
        h_st       <= mode_sel ? IV_224 : IV_256;
        finalizing <= 1'b0;
        need_len   <= 1'b0;
        len_only   <= 1'b0;
        is_224     <= mode_sel;
        overflow   <= 1'b0;
      end else begin
        if (ovf_evt) overflow <= 1'b1;
        case (st)
          ST_ABSORB: begin
            if (acc_final) begin
              st         <= ST_PAD;
              finalizing <= 1'b1;
            end else if (acc_update) begin
              bit_len <= bit_len + {54'd0, bv_eff, 3'b000};
              if (blk_full) begin
                st  <= ST_COMPRESS;
                blk <= '0;
                cnt <= '0;
              end else begin
                blk <= blk_merge;
                cnt <= cnt_merge;
              end
            end
          end
          ST_PAD: begin
            need_len <= !len_only && (cnt > 7'd55);
            blk      <= '0;
            cnt      <= '0;
            st       <= ST_COMPRESS;
          end
          ST_COMPRESS: begin
            if (cmp_done) begin
              h_st <= h_new;
              if (!finalizing) begin
                st <= ST_ABSORB;
              end else if (need_len) begin
                st       <= ST_PAD;
                len_only <= 1'b1;
                need_len <= 1'b0;
              end else begin
                st         <= ST_DONE;
                hash       <= is_224 ? {h_new[255:32], 32'h0} : h_new;
                hash_valid <= 1'b1;
              end
            end
          end
          ST_DONE: st <= ST_IDLE;
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_streaming_sha256_wide.sv
// -----------------------------------------------------------------------------
// tb_streaming_sha256_wide
// Scoreboard bench: two hashers (IN_BYTES=4 and IN_BYTES=8) share clk/rst.
// Each finalize pushes the expected digest and the expected hash_valid cycle;
// a per-DUT monitor pops and compares whenever hash_valid is seen.
// Define STREAMING_SHA256_SHA224_EN to add the SHA-224 case.
// -----------------------------------------------------------------------------
module tb_streaming_sha256_wide;

  typedef struct {
    logic [255:0] digest;
    int           cyc;
  } exp_t;

  localparam logic [255:0] D_A     = 256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_A64   = 256'hd53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6;
  localparam logic [255:0] D_A63   = 256'h1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t sb4[$];
  exp_t sb8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // IN_BYTES = 4 instance
  logic         start4, upd4, fin4, rdy4, hv4, ovf4;
  logic [31:0]  data4;
  logic [2:0]   bv4;
  logic [255:0] hash4;
`ifdef STREAMING_SHA256_SHA224_EN
  logic         mode4;
`endif

  // IN_BYTES = 8 instance
  logic         start8, upd8, fin8, rdy8, hv8, ovf8;
  logic [63:0]  data8;
  logic [3:0]   bv8;
  logic [255:0] hash8;

  streaming_sha256_wide #(.IN_BYTES(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
`ifdef STREAMING_SHA256_SHA224_EN
    .mode_224    (mode4),
`endif
    .update      (upd4),
    .data_in     (data4),
    .bytes_valid (bv4),
    .finalize    (fin4),
    .ready       (rdy4),
    .hash_valid  (hv4),
    .hash        (hash4),
    .overflow    (ovf4)
  );

  streaming_sha256_wide #(.IN_BYTES(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
`ifdef STREAMING_SHA256_SHA224_EN
    .mode_224    (1'b0),
`endif
    .update      (upd8),
    .data_in     (data8),
    .bytes_valid (bv8),
    .finalize    (fin8),
    .ready       (rdy8),
    .hash_valid  (hv8),
    .hash        (hash8),
    .overflow    (ovf8)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every hash_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && hv4) begin
      if (sb4.size() == 0) begin
        check("hv4_unexpected", {255'd0, hv4}, 256'd0);
      end else begin
        exp_t e;
        e = sb4.pop_front();
        check("hash4", hash4, e.digest);
        check("hv4_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && hv8) begin
      if (sb8.size() == 0) begin
        check("hv8_unexpected", {255'd0, hv8}, 256'd0);
      end else begin
        exp_t e;
        e = sb8.pop_front();
        check("hash8", hash8, e.digest);
        check("hv8_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  task automatic wait_rdy4();
    int n = 0;
    @(negedge clk);
    while (!rdy4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy4) check("rdy4_timeout", {255'd0, rdy4}, 256'd1);
  endtask

  task automatic start4_t(input logic with_beat);
    @(negedge clk);
    start4 = 1'b1;
    upd4   = with_beat;
    data4  = 32'h7a7a7a7a;
    bv4    = 3'd4;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    upd4   = 1'b0;
    @(negedge clk);
    check("rdy4_after_start", {255'd0, rdy4}, 256'd1);
  endtask

  task automatic beat4(input logic [31:0] d, input logic [2:0] bv);
    wait_rdy4();
    upd4  = 1'b1;
    data4 = d;
    bv4   = bv;
    @(posedge clk);
    #1;
    upd4 = 1'b0;
  endtask

  task automatic fin4_t(input logic [255:0] dg, input int lat);
    wait_rdy4();
    fin4 = 1'b1;
    sb4.push_back('{dg, cyc + lat});
    @(posedge clk);
    #1;
    fin4 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 256'(sb4.size() + sb8.size()), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start4 = 1'b0; upd4 = 1'b0; fin4 = 1'b0; data4 = '0; bv4 = '0;
    start8 = 1'b0; upd8 = 1'b0; fin8 = 1'b0; data8 = '0; bv8 = '0;
`ifdef STREAMING_SHA256_SHA224_EN
    mode4 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_ready",      {255'd0, rdy4}, 256'd0);
    check("rst_hash_valid", {255'd0, hv4},  256'd0);
    check("rst_hash",       hash4,          256'd0);
    check("rst_overflow",   {255'd0, ovf4}, 256'd0);

    // "a" preceded by a zero-byte beat; unused lanes carry garbage
    start4_t(1'b0);
    beat4(32'hffffffff, 3'd0);
    beat4(32'h615a5a5a, 3'd1);
    fin4_t(D_A, 67);
    drain();

    // Empty message
    start4_t(1'b0);
    fin4_t(D_EMPTY, 67);
    drain();

    // 63 x 'A': length does not fit, two pad blocks
    start4_t(1'b0);
    for (int i = 0; i < 15; i++) beat4(32'h41414141, 3'd4);
    beat4(32'h414141ff, 3'd3);
    fin4_t(D_A63, 133);
    drain();

    // Beats while busy are dropped and flag overflow
    start4_t(1'b0);
    for (int i = 0; i < 16; i++) beat4(32'h41414141, 3'd4);
    @(negedge clk);
    upd4  = 1'b1;
    data4 = 32'hffffffff;
    bv4   = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    upd4 = 1'b0;
    @(negedge clk);
    check("overflow_set", {255'd0, ovf4}, 256'd1);
    fin4_t(D_A64, 67);
    drain();
    check("overflow_sticky", {255'd0, ovf4}, 256'd1);

    // start beats a same-cycle update, clears overflow, and aborts mid-message
    start4_t(1'b1);
    check("overflow_cleared", {255'd0, ovf4}, 256'd0);
    beat4(32'h41414141, 3'd4);
    beat4(32'h42424242, 3'd4);
    start4_t(1'b0);
    beat4(32'h61000000, 3'd1);
    fin4_t(D_A, 67);
    drain();
    check("overflow_after_restart", {255'd0, ovf4}, 256'd0);

`ifdef STREAMING_SHA256_SHA224_EN
    // SHA-224 of "abc"
    @(negedge clk);
    start4 = 1'b1;
    mode4  = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    mode4  = 1'b0;
    beat4(32'h616263ee, 3'd3);
    fin4_t({224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, 67);
    drain();
`endif

    // IN_BYTES = 8: 64 x 'A' in eight beats, ready low for exactly 65 cycles
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rdy8_beat", {255'd0, rdy8}, 256'd1);
      upd8  = 1'b1;
      data8 = 64'h4141414141414141;
      bv8   = 4'd8;
      @(posedge clk);
      #1;
      upd8 = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!rdy8 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("rdy8_low_cycles", 256'(n), 256'd65);
    fin8 = 1'b1;
    sb8.push_back('{D_A64, cyc + 67});
    @(posedge clk);
    #1;
    fin8 = 1'b0;
    drain();

    // Reset in the middle of a compression
    start4_t(1'b0);
    for (int i = 0; i < 16; i++) beat4(32'h41414141, 3'd4);
    @(negedge clk);
    upd4 = 1'b1;
    @(posedge clk);
    #1;
    upd4 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready",      {255'd0, rdy4}, 256'd0);
    check("mid_rst_hash_valid", {255'd0, hv4},  256'd0);
    check("mid_rst_hash",       hash4,          256'd0);
    check("mid_rst_overflow",   {255'd0, ovf4}, 256'd0);
    check("mid_rst_hash8",      hash8,          256'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", {255'd0, rdy4}, 256'd0);
    check("post_rst_hash",  hash4,          256'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
